parallel_to_serial: RTL

//  Transmit-side counterpart of the serial_to_parallel deserialiser.

---
 rtl/parallel_to_serial_pkg.sv | 15 +
 rtl/parallel_to_serial_bit_counter.sv | 46 ++++
 rtl/parallel_to_serial.sv | 99 +++++++++
 3 files changed

// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the serialiser and its deserialiser counterpart:
// FSM state encoding and the bit-counter width helper.
package parallel_to_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter width for a word of n bits (n >= 2).
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/parallel_to_serial_bit_counter.sv
// Mod-N up-counter with synchronous clear and enable; tc flags the count N-1,
// which marks the last bit of a word on the serial line.
module bit_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over enable, wrap at N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {W{1'b0}};
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter: accepts an N-bit word on load && ready and
// shifts it out one bit per clock, streaming back-to-back words gap-free.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         load,
  output logic         ready,
  output logic         data_out,
  output logic         busy,
  output logic         done_tick
);

  localparam int CW = cnt_width(N);

  state_e       state_q;
  state_e       state_d;
  logic [N-1:0] sreg_q;
  logic [N-1:0] sreg_d;
  logic         cnt_clear;
  logic         cnt_en;
  logic         last_bit;

  bit_counter #(
    .N (N),
    .W (CW)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (last_bit)
  );

  // Next-state and shift-register update.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          sreg_d    = data_in;
          state_d   = SHIFT;
          cnt_clear = 1'b1;
        end else begin
          sreg_d    = {N{1'b0}};
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_clear = 1'b1;
          if (load) begin
            // Next word follows with no idle gap.
            sreg_d = data_in;
          end else begin
            sreg_d  = {N{1'b0}};
            state_d = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
          if (LSB_FIRST != 0) begin
            sreg_d = {1'b0, sreg_q[N-1:1]};
          end else begin
            sreg_d = {sreg_q[N-2:0], 1'b0};
          end
        end
      end
      default: begin
        state_d   = IDLE;
        sreg_d    = {N{1'b0}};
        cnt_clear = 1'b1;
      end
    endcase
  end

  // State and shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= {N{1'b0}};
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done_tick = busy && last_bit;
  assign ready     = (state_q == IDLE) || done_tick;
  assign data_out  = busy ? ((LSB_FIRST != 0) ? sreg_q[0] : sreg_q[N-1]) : 1'b0;

endmodule
